// File: rtl/data_mem_responder.sv
// data_mem_responder: memory-side responder for the processor data port.
// Serves word reads/writes against an on-chip RAM and answers with a one-cycle
// DataDone pulse LATENCY cycles after the accept edge. With LATENCY=1 a request
// can be taken every cycle; otherwise one request is in flight and Busy is high
// while it waits.
// Optional feature macro: DATA_MEM_MMIO_EN adds an LED output register at
// 16'hFFF0 and a switch input at 16'hFFF1 (LedOut/SwIn ports).
module data_mem_responder #(
    parameter int WORD_SIZE = 16,
    parameter int DEPTH     = 256,
    parameter int LATENCY   = 1
) (
    input  logic                 Clock,
    input  logic                 Resetn,
    input  logic [WORD_SIZE-1:0] DataAddr,
    input  logic [WORD_SIZE-1:0] DataOut,
    input  logic                 ReadData,
    input  logic                 WriteData,
    output logic [WORD_SIZE-1:0] DataIn,
    output logic                 DataDone,
    output logic                 Busy,
    output logic                 Error
`ifdef DATA_MEM_MMIO_EN
    ,
    output logic [WORD_SIZE-1:0] LedOut,
    input  logic [WORD_SIZE-1:0] SwIn
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Last WAIT count before moving to RESP; unreachable when LATENCY=1.
    localparam logic [1:0] CNT_LAST = 2'(LATENCY - 2);
    localparam logic [WORD_SIZE-1:0] MMIO_LED = WORD_SIZE'(16'hFFF0);
    localparam logic [WORD_SIZE-1:0] MMIO_SW  = WORD_SIZE'(16'hFFF1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic [1:0] cnt, cnt_nxt;
    logic       done_nxt;

    logic [WORD_SIZE-1:0] mem [DEPTH];

    logic                 req_one, req_both, accept;
    logic                 in_range, mmio_led, mmio_sw, addr_ok;
    logic [AW-1:0]        idx;
    logic [WORD_SIZE-1:0] rd_val;
    logic                 ram_we, err_set;

    // Pending request captured at the accept edge (used when LATENCY>1).
    logic                 pend_rd;
    logic [WORD_SIZE-1:0] pend_data;
    logic                 resp_rd;
    logic [WORD_SIZE-1:0] resp_data;

    assign Busy     = (state == S_WAIT);
    assign req_one  = ReadData ^ WriteData;
    assign req_both = ReadData & WriteData;
    assign accept   = req_one & ~Busy;

    assign in_range = (32'(DataAddr) < DEPTH);
    assign idx      = DataAddr[AW-1:0];

`ifdef DATA_MEM_MMIO_EN
    assign mmio_led = (DataAddr == MMIO_LED);
    assign mmio_sw  = (DataAddr == MMIO_SW);
`else
    assign mmio_led = 1'b0;
    assign mmio_sw  = 1'b0;
`endif

    assign addr_ok = in_range | mmio_led | mmio_sw;
    assign ram_we  = accept & WriteData & in_range;

    // Anything malformed or unserviceable raises the sticky error.
    assign err_set = req_both | (req_one & Busy) | (accept & ~addr_ok);

    // Read value as seen at the accept edge; unmapped addresses read as zero.
    always_comb begin
        rd_val = '0;
        if (in_range) begin
            rd_val = mem[idx];
        end
`ifdef DATA_MEM_MMIO_EN
        else if (mmio_led) begin
            rd_val = LedOut;
        end else if (mmio_sw) begin
            rd_val = SwIn;
        end
`endif
    end

    // With LATENCY=1 the response is formed from the request being accepted
    // right now; otherwise from what was captured at the accept edge.
    assign resp_rd   = (LATENCY == 1) ? ReadData : pend_rd;
    assign resp_data = (LATENCY == 1) ? rd_val   : pend_data;

    // RAM array: writes commit at the accept edge, contents are never reset.
    always_ff @(posedge Clock) begin
        if (ram_we) begin
            mem[idx] <= DataOut;
        end
    end

    // Next state and response strobe. RESP is the DataDone cycle; Busy is low
    // there, so a new request is taken on the edge that ends it.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        case (state)
            S_IDLE, S_RESP: begin
                state_nxt = S_IDLE;
                if (accept) begin
                    cnt_nxt = '0;
                    if (LATENCY == 1) begin
                        state_nxt = S_RESP;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = S_RESP;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + 2'd1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State, counter, registered outputs and pending-request capture.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state     <= S_IDLE;
            cnt       <= '0;
            DataDone  <= 1'b0;
            DataIn    <= '0;
            Error     <= 1'b0;
            pend_rd   <= 1'b0;
            pend_data <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            DataDone <= done_nxt;
            if (done_nxt && resp_rd) begin
                DataIn <= resp_data;
            end
            if (err_set) begin
                Error <= 1'b1;
            end
            if (accept) begin
                pend_rd   <= ReadData;
                pend_data <= rd_val;
            end
        end
    end

`ifdef DATA_MEM_MMIO_EN
    // LED register: written at the accept edge of a write to its address.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            LedOut <= '0;
        end else if (accept && WriteData && mmio_led) begin
            LedOut <= DataOut;
        end
    end
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (LATENCY 1, 3, 4) with
// independent stimulus and resets; a scoreboard queue holds the expected
// DataDone cycle and DataIn value of every accepted request.
module tb_data_mem_responder;

    logic Clock = 1'b0;
    always #5 Clock = ~Clock;

    logic [2:0]  rstn, rd, wr, dd, bsy, err;
    logic [15:0] addr [3];
    logic [15:0] wd   [3];
    logic [15:0] din  [3];
`ifdef DATA_MEM_MMIO_EN
    logic [15:0] led [3];
    logic [15:0] sw;
    logic [15:0] led_mdl;
`endif

    typedef struct {
        int          d;
        int          cyc;
        logic [15:0] data;
    } exp_t;

    exp_t        sbq [$];
    exp_t        mon_e;
    logic [15:0] mdl [3][256];
    logic [15:0] last_rd [3];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    always @(posedge Clock) cyc <= cyc + 1;

    data_mem_responder #(.WORD_SIZE(16), .DEPTH(256), .LATENCY(1)) u0 (
        .Clock(Clock), .Resetn(rstn[0]), .DataAddr(addr[0]), .DataOut(wd[0]),
        .ReadData(rd[0]), .WriteData(wr[0]), .DataIn(din[0]), .DataDone(dd[0]),
        .Busy(bsy[0]), .Error(err[0])
`ifdef DATA_MEM_MMIO_EN
        , .LedOut(led[0]), .SwIn(sw)
`endif
    );
    data_mem_responder #(.WORD_SIZE(16), .DEPTH(256), .LATENCY(3)) u1 (
        .Clock(Clock), .Resetn(rstn[1]), .DataAddr(addr[1]), .DataOut(wd[1]),
        .ReadData(rd[1]), .WriteData(wr[1]), .DataIn(din[1]), .DataDone(dd[1]),
        .Busy(bsy[1]), .Error(err[1])
`ifdef DATA_MEM_MMIO_EN
        , .LedOut(led[1]), .SwIn(sw)
`endif
    );
    data_mem_responder #(.WORD_SIZE(16), .DEPTH(256), .LATENCY(4)) u2 (
        .Clock(Clock), .Resetn(rstn[2]), .DataAddr(addr[2]), .DataOut(wd[2]),
        .ReadData(rd[2]), .WriteData(wr[2]), .DataIn(din[2]), .DataDone(dd[2]),
        .Busy(bsy[2]), .Error(err[2])
`ifdef DATA_MEM_MMIO_EN
        , .LedOut(led[2]), .SwIn(sw)
`endif
    );

    function automatic int lat(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 3 : 4);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge: drive a request, let one posedge take it, record the
    // expected response if it should be accepted, return at the next negedge
    // with the strobes still driven.
    task automatic req(input int d, input bit r, input bit w, input logic [15:0] a,
                       input logic [15:0] data, input bit acc);
        exp_t e;
        rd[d] = r; wr[d] = w; addr[d] = a; wd[d] = data;
        @(posedge Clock);
        #1;
        if (acc) begin
            if (r) begin
                last_rd[d] = (a < 16'd256) ? mdl[d][a[7:0]] : 16'h0000;
`ifdef DATA_MEM_MMIO_EN
                if (a == 16'hFFF0) last_rd[d] = led_mdl;
                if (a == 16'hFFF1) last_rd[d] = sw;
`endif
            end
            if (w && a < 16'd256) mdl[d][a[7:0]] = data;
`ifdef DATA_MEM_MMIO_EN
            if (w && a == 16'hFFF0) led_mdl = data;
`endif
            e.d = d; e.cyc = cyc + lat(d) - 1; e.data = last_rd[d];
            sbq.push_back(e);
        end
        @(negedge Clock);
    endtask

    task automatic idle(input int d, input int n);
        rd[d] = 1'b0; wr[d] = 1'b0;
        repeat (n) @(negedge Clock);
    endtask

    // Every DataDone must match the oldest expected response: same instance,
    // exact cycle and DataIn value.
    always @(negedge Clock) begin
        for (int i = 0; i < 3; i++) begin
            if (dd[i] === 1'b1) begin
                chk("sb_has_entry", 32'(sbq.size() != 0), 32'd1);
                if (sbq.size() != 0) begin
                    mon_e = sbq.pop_front();
                    chk("done_dut", 32'(i), 32'(mon_e.d));
                    chk("done_cyc", 32'(cyc), 32'(mon_e.cyc));
                    chk("done_data", {16'h0, din[i]}, {16'h0, mon_e.data});
                end
            end
        end
    end

    initial begin
        rstn = 3'b000; rd = 3'b000; wr = 3'b000;
        for (int i = 0; i < 3; i++) begin
            addr[i] = '0; wd[i] = '0; last_rd[i] = '0;
        end
`ifdef DATA_MEM_MMIO_EN
        sw = 16'h5A5A; led_mdl = 16'h0000;
`endif
        repeat (2) @(negedge Clock);
        for (int i = 0; i < 3; i++) begin
            chk("rst_datain", {16'h0, din[i]}, 32'h0);
            chk("rst_done", {31'h0, dd[i]}, 32'h0);
            chk("rst_busy", {31'h0, bsy[i]}, 32'h0);
            chk("rst_error", {31'h0, err[i]}, 32'h0);
        end
        rstn = 3'b111;
        @(negedge Clock);

        // ---- LATENCY=1: back-to-back write/read, out-of-range aliasing ----
        req(0, 0, 1, 16'd5, 16'h1234, 1);
        chk("l1_busy_w", {31'h0, bsy[0]}, 32'h0);
        req(0, 1, 0, 16'd5, 16'h0000, 1);
        chk("l1_busy_r", {31'h0, bsy[0]}, 32'h0);
        idle(0, 2);
        chk("l1_err0", {31'h0, err[0]}, 32'h0);
        req(0, 0, 1, 16'd44, 16'h4444, 1);
        req(0, 0, 1, 16'd300, 16'hBEEF, 1);
        idle(0, 1);
        chk("oor_wr_err", {31'h0, err[0]}, 32'h1);
        req(0, 1, 0, 16'd44, 16'h0000, 1);
        req(0, 1, 0, 16'd300, 16'h0000, 1);
        idle(0, 2);
        rstn[0] = 1'b0;
        #1;
        chk("l1_rst_err", {31'h0, err[0]}, 32'h0);
        last_rd[0] = 16'h0000;
        @(negedge Clock);
        rstn[0] = 1'b1;
        @(negedge Clock);
`ifdef DATA_MEM_MMIO_EN
        req(0, 0, 1, 16'hFFF0, 16'h00F0, 1);
        req(0, 1, 0, 16'hFFF1, 16'h0000, 1);
        idle(0, 2);
        chk("mmio_led", {16'h0, led[0]}, 32'h00F0);
        chk("mmio_err", {31'h0, err[0]}, 32'h0);
`else
        req(0, 1, 0, 16'hFFF0, 16'h0000, 1);
        idle(0, 2);
        chk("fff0_err", {31'h0, err[0]}, 32'h1);
`endif

        // ---- LATENCY=3: Busy window, request while Busy dropped ----
        req(1, 0, 1, 16'd7, 16'h00AA, 1);
        idle(1, 3);
        req(1, 1, 0, 16'd7, 16'h0000, 1);
        chk("l3_busy1", {31'h0, bsy[1]}, 32'h1);
        req(1, 1, 0, 16'd8, 16'h0000, 0);
        chk("l3_busy2", {31'h0, bsy[1]}, 32'h1);
        chk("l3_drop_err", {31'h0, err[1]}, 32'h1);
        idle(1, 1);
        chk("l3_done_busy", {31'h0, bsy[1]}, 32'h0);
        chk("l3_done", {31'h0, dd[1]}, 32'h1);
        idle(1, 4);
        req(1, 1, 0, 16'd300, 16'h0000, 1);
        idle(1, 4);

        // ---- LATENCY=4: both strobes, reset abort during WAIT ----
        req(2, 0, 1, 16'd9, 16'h0999, 1);
        idle(2, 4);
        req(2, 0, 1, 16'd3, 16'h0333, 1);
        idle(2, 4);
        req(2, 1, 1, 16'd3, 16'hFFFF, 0);
        idle(2, 0);
        chk("both_err", {31'h0, err[2]}, 32'h1);
        chk("both_busy", {31'h0, bsy[2]}, 32'h0);
        idle(2, 4);
        req(2, 1, 0, 16'd3, 16'h0000, 1);
        idle(2, 0);
        chk("l4_busy", {31'h0, bsy[2]}, 32'h1);
        rstn[2] = 1'b0;
        #1;
        chk("abort_busy", {31'h0, bsy[2]}, 32'h0);
        chk("abort_done", {31'h0, dd[2]}, 32'h0);
        chk("abort_err", {31'h0, err[2]}, 32'h0);
        chk("abort_din", {16'h0, din[2]}, 32'h0);
        void'(sbq.pop_back());
        last_rd[2] = 16'h0000;
        repeat (2) @(negedge Clock);
        rstn[2] = 1'b1;
        idle(2, 6);
        req(2, 1, 0, 16'd9, 16'h0000, 1);
        idle(2, 4);
        req(2, 1, 0, 16'd3, 16'h0000, 1);
        idle(2, 5);
        chk("l4_err_after", {31'h0, err[2]}, 32'h0);

        chk("sb_empty", 32'(sbq.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
